// File: rtl/inv_keyexpansion.sv
// -----------------------------------------------------------------------------
// inv_keyexpansion
//   Decryption-side AES-128 key schedule. On start the cipher key is loaded and
//   the schedule is run forward to the round-10 key. The schedule is then walked
//   backward, presenting round keys 10 down to 0 on a valid/ready stream. This
//   is the order the inverse cipher consumes them. Only one 128-bit round key
//   and the current rcon are held.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   start     one-cycle pulse; samples key and begins expansion (ignored if busy)
//   key       cipher key, bits [127:96] = w0
//   roundKey  current round key, bits [127:96] = first word
//   roundIdx  round number of roundKey (10..0)
//   keyValid  roundKey/roundIdx valid
//   keyReady  consumer accepts roundKey on this cycle
//   busy      high from accepted start until round 0 is accepted
// -----------------------------------------------------------------------------
module inv_keyexpansion #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] roundKey,
    output logic [3:0]   roundIdx,
    output logic         keyValid,
    input  logic         keyReady,
    output logic         busy
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("inv_keyexpansion supports AES-128 only: NR must be 10");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [7:0]   rcon_reg, rcon_next;
    logic [3:0]   fwd_cnt_reg, fwd_cnt_next;
    logic [3:0]   idx_reg, idx_next;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] bwd_w3;
    logic [31:0] sub_in, sub_out, g_word;
    logic [31:0] f0, f1, f2, f3;
    logic [127:0] fwd_key, bwd_key;
    logic [7:0]  rcon_dbl, rcon_half;

    assign {w0, w1, w2, w3} = key_reg;

    // The backward step needs SubWord of the recovered w3 (w3 ^ w2), the
    // forward step needs SubWord of w3; only one direction is active at a
    // time so a single four-byte S-box bank is shared.
    assign bwd_w3 = w3 ^ w2;
    assign sub_in = (state_reg == BWD) ? bwd_w3 : w3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_out[8*gi +: 8] = SBOX[sub_in[8*gi +: 8]];
        end
    endgenerate

    // S-box is bytewise, so rotating after substitution equals SubWord(RotWord()).
    assign g_word = {sub_out[23:0], sub_out[31:24]} ^ {rcon_reg, 24'h0};

    assign f0      = w0 ^ g_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
    assign bwd_key = {w0 ^ g_word, w1 ^ w0, w2 ^ w1, bwd_w3};

    // GF(2^8) doubling and its inverse (halving) for rcon.
    assign rcon_dbl  = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
    assign rcon_half = {1'b0, rcon_reg[7:1]} ^ (rcon_reg[0] ? 8'h8d : 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            key_reg     <= '0;
            rcon_reg    <= 8'h01;
            fwd_cnt_reg <= '0;
            idx_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            key_reg     <= key_next;
            rcon_reg    <= rcon_next;
            fwd_cnt_reg <= fwd_cnt_next;
            idx_reg     <= idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        key_next     = key_reg;
        rcon_next    = rcon_reg;
        fwd_cnt_next = fwd_cnt_reg;
        idx_next     = idx_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    key_next     = key;
                    rcon_next    = 8'h01;
                    fwd_cnt_next = 4'd1;
                    state_next   = FWD;
                end
            end
            FWD: begin
                key_next = fwd_key;
                if (fwd_cnt_reg == 4'd10) begin
                    // rcon stays at 0x36: it is exactly the value the first
                    // backward step needs.
                    idx_next   = 4'd10;
                    state_next = BWD;
                end else begin
                    rcon_next    = rcon_dbl;
                    fwd_cnt_next = fwd_cnt_reg + 4'd1;
                end
            end
            BWD: begin
                if (keyReady) begin
                    if (idx_reg != 4'd0) begin
                        key_next  = bwd_key;
                        rcon_next = rcon_half;
                        idx_next  = idx_reg - 4'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign roundKey = key_reg;
    assign roundIdx = idx_reg;
    assign keyValid = (state_reg == BWD);
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_inv_keyexpansion.sv
// -----------------------------------------------------------------------------
// tb_inv_keyexpansion
//   Directed-vector bench for inv_keyexpansion using published AES-128 round
//   keys (FIPS-197 example key and the all-zero key).
// -----------------------------------------------------------------------------
module tb_inv_keyexpansion;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] roundKey;
    logic [3:0]   roundIdx;
    logic         keyValid;
    logic         keyReady;
    logic         busy;

    int n_vec;
    int n_err;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    // FIPS-197 round keys, indexed by round number
    logic [127:0] fips_rk [0:10];
    // transfers in acceptance order
    logic [127:0] got_key [0:10];
    logic [3:0]   got_idx [0:10];
    int           n_xfer;

    inv_keyexpansion #(.NR(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .roundKey (roundKey),
        .roundIdx (roundIdx),
        .keyValid (keyValid),
        .keyReady (keyReady),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses start for one edge, returns at the next negedge.
    task automatic do_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
        key   = 128'h0;
    endtask

    // Called at a negedge. bp=1: random keyReady with a 5-cycle hold at round 6.
    // pulse=1: extra start pulses during FWD and during BWD.
    task automatic collect(input int bp, input int pulse);
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        logic         stall;
        int           hold;
        logic         did_hold;
        n_xfer   = 0;
        stall    = 1'b0;
        hold     = 0;
        did_hold = 1'b0;
        prev_key = '0;
        prev_idx = '0;
        for (int cyc = 0; cyc < 300 && n_xfer < 11; cyc++) begin
            if (stall) begin
                check_vec("stall_key", roundKey, prev_key);
                check_vec("stall_idx", 128'(roundIdx), 128'(prev_idx));
            end
            if (bp == 0) begin
                keyReady = 1'b1;
            end else if (hold > 0) begin
                keyReady = 1'b0;
                hold--;
            end else if (keyValid && roundIdx == 4'd6 && !did_hold) begin
                keyReady = 1'b0;
                hold     = 4;
                did_hold = 1'b1;
            end else begin
                keyReady = 1'($urandom_range(0, 1));
            end
            start = (pulse != 0) && (cyc == 3 || cyc == 15);
            key   = start ? 128'hdeadbeef_00112233_44556677_8899aabb : 128'h0;
            stall    = keyValid && !keyReady;
            prev_key = roundKey;
            prev_idx = roundIdx;
            if (keyValid && keyReady) begin
                got_key[n_xfer] = roundKey;
                got_idx[n_xfer] = roundIdx;
                $display("xfer %0d: roundIdx=%0d roundKey=%h", n_xfer, roundIdx, roundKey);
                n_xfer++;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        keyReady = 1'b0;
        check_vec("n_xfer", 128'(n_xfer), 128'd11);
        check_vec("busy_end", 128'(busy), 128'd0);
        check_vec("valid_end", 128'(keyValid), 128'd0);
    endtask

    task automatic check_fips(input string tag);
        for (int i = 0; i < 11; i++) begin
            check_vec({tag, "_idx"}, 128'(got_idx[i]), 128'(10 - i));
            check_vec({tag, "_key"}, got_key[i], fips_rk[10 - i]);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 11; i++)
            check_vec({tag, "_idx"}, 128'(got_idx[i]), 128'(10 - i));
        check_vec({tag, "_r10"}, got_key[0],  128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check_vec({tag, "_r1"},  got_key[9],  128'h62636363626363636263636362636363);
        check_vec({tag, "_r0"},  got_key[10], 128'h0);
    endtask

    initial begin
        int  lat;
        logic found;
        n_vec = 0;
        n_err = 0;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset    = 1'b1;
        start    = 1'b0;
        key      = 128'h0;
        keyReady = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("rst_valid", 128'(keyValid), 128'd0);
        check_vec("rst_busy",  128'(busy),     128'd0);
        check_vec("rst_key",   roundKey,       128'h0);
        check_vec("rst_idx",   128'(roundIdx), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // FIPS key: latency, then full sequence with keyReady high
        do_start(FIPS_KEY);
        check_vec("busy_after_start", 128'(busy), 128'd1);
        lat = 0;
        while (!keyValid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check_vec("latency", 128'(lat), 128'd10);
        check_vec("first_idx", 128'(roundIdx), 128'd10);
        collect(0, 0);
        check_fips("fips");

        // back-to-back: start the cycle after the round-0 handshake
        do_start(ZERO_KEY);
        collect(0, 0);
        check_zero("b2b_zero");
        do_start(FIPS_KEY);
        collect(0, 0);
        check_fips("b2b_fips");

        // backpressure
        do_start(FIPS_KEY);
        collect(1, 0);
        check_fips("bp");

        // start pulses while busy must be ignored
        do_start(FIPS_KEY);
        collect(0, 1);
        check_fips("restart_ign");

        // asynchronous reset at roundIdx 4
        do_start(FIPS_KEY);
        keyReady = 1'b1;
        found    = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (keyValid && roundIdx == 4'd4) found = 1'b1;
            else @(negedge clk);
        end
        check_vec("reach_idx4", 128'(found), 128'd1);
        #2 reset = 1'b1;
        #1;
        check_vec("arst_valid", 128'(keyValid), 128'd0);
        check_vec("arst_busy",  128'(busy),     128'd0);
        check_vec("arst_key",   roundKey,       128'h0);
        keyReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_start(ZERO_KEY);
        collect(0, 0);
        check_zero("post_rst_zero");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
